// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe game controller: cell and winner
// encodings, controller states, the board type and the table of winning lines.
package ttt_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_HUMAN = 2'b01,
    CELL_AI    = 2'b10
  } cell_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_HUMAN = 2'b01;
  localparam logic [1:0] WIN_AI    = 2'b10;
  localparam logic [1:0] WIN_DRAW  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HUMAN,
    S_AI_WAIT,
    S_AI_MOVE,
    S_EVAL_H,
    S_EVAL_A,
    S_DONE
  } state_t;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  // Element 0 holds cell 1, element 8 holds cell 9.
  typedef logic [NUM_CELLS-1:0][1:0] board_t;

  // Winning lines as 1-based cell-index triples.
  localparam logic [3:0] LINE_TBL [NUM_LINES][3] = '{
    '{4'd1, 4'd2, 4'd3},
    '{4'd4, 4'd5, 4'd6},
    '{4'd7, 4'd8, 4'd9},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd3, 4'd6, 4'd9},
    '{4'd1, 4'd5, 4'd9},
    '{4'd3, 4'd5, 4'd7}
  };

  // True for a legal 1-based cell index.
  function automatic logic is_cell_index(input logic [3:0] idx);
    return (idx >= 4'd1) && (idx <= 4'd9);
  endfunction

  // Contents of 1-based cell idx; out-of-range indices read as empty.
  function automatic logic [1:0] cell_at(input board_t b, input logic [3:0] idx);
    logic [1:0] val;
    val = CELL_EMPTY;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (idx == 4'(i + 1)) val = b[i];
    end
    return val;
  endfunction

  // True when every cell of line l belongs to the given owner.
  function automatic logic line_has(input board_t b, input int l, input logic [1:0] who);
    return (cell_at(b, LINE_TBL[l][0]) == who) &&
           (cell_at(b, LINE_TBL[l][1]) == who) &&
           (cell_at(b, LINE_TBL[l][2]) == who);
  endfunction

endpackage

// File: rtl/line_eval.sv
// Purely combinational board evaluator: reports a completed human line,
// a completed AI line, and whether every cell is occupied.
module line_eval
  import ttt_pkg::*;
(
  input  board_t board,
  output logic   human_win,
  output logic   ai_win,
  output logic   full
);

  // Scan all eight lines and all nine cells.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    human_win = 1'b0;
    ai_win    = 1'b0;
    full      = 1'b1;
    for (int l = 0; l < NUM_LINES; l++) begin
      if (line_has(board, l, CELL_HUMAN)) human_win = 1'b1;
      if (line_has(board, l, CELL_AI))    ai_win    = 1'b1;
    end
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (board[i] == CELL_EMPTY) full = 1'b0;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Tic-tac-toe game controller: holds the board, accepts human moves,
// places the AI reply (using the external checkwin hint) and declares
// the result. The checkwin block sits beside this one at the top level.
module game_ctrl
  import ttt_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic       move_ready,
  input  logic       check,
  input  logic [3:0] blockthis,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic       illegal,
  output logic       game_over,
  output logic [1:0] winner
);

  state_t     r_state;
  state_t     w_next_state;
  board_t     r_board;
  logic [1:0] r_winner;
  logic       r_illegal;

  logic       w_human_win;
  logic       w_ai_win;
  logic       w_full;
  logic       w_move_legal;
  logic [3:0] w_ai_idx;
  logic       w_ai_found;

  logic       w_clear;
  logic       w_human_we;
  logic       w_ai_we;
  logic       w_reject;
  logic       w_winner_we;
  logic [1:0] w_winner_nxt;

  line_eval u_line_eval (
    .board     (r_board),
    .human_win (w_human_win),
    .ai_win    (w_ai_win),
    .full      (w_full)
  );

  // A human move is acceptable when it names a real cell that is still empty.
  assign w_move_legal = move_valid && is_cell_index(move_pos) &&
                        (cell_at(r_board, move_pos) == CELL_EMPTY);

  // AI cell choice: checkwin hint if usable, else the centre, else the lowest empty cell.
  always_comb begin
    w_ai_idx   = 4'd0;
    w_ai_found = 1'b0;
    if (check && is_cell_index(blockthis) && (cell_at(r_board, blockthis) == CELL_EMPTY)) begin
      w_ai_idx   = blockthis;
      w_ai_found = 1'b1;
    end else if (r_board[4] == CELL_EMPTY) begin
      w_ai_idx   = 4'd5;
      w_ai_found = 1'b1;
    end else begin
      // Descending scan so the lowest empty index is the last one kept.
      for (int i = NUM_CELLS - 1; i >= 0; i--) begin
        if (r_board[i] == CELL_EMPTY) begin
          w_ai_idx   = 4'(i + 1);
          w_ai_found = 1'b1;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next_state = S_HUMAN;
      S_HUMAN:   if (w_move_legal) w_next_state = S_EVAL_H;
      S_EVAL_H:  w_next_state = (w_human_win || w_full) ? S_DONE : S_AI_WAIT;
      S_AI_WAIT: w_next_state = S_AI_MOVE;
      S_AI_MOVE: w_next_state = S_EVAL_A;
      S_EVAL_A:  w_next_state = (w_ai_win || w_full) ? S_DONE : S_HUMAN;
      S_DONE:    if (start) w_next_state = S_HUMAN;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Output and datapath-control decode from the current state.
  always_comb begin
    move_ready   = (r_state == S_HUMAN);
    game_over    = (r_state == S_DONE);
    w_clear      = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
    w_human_we   = (r_state == S_HUMAN) && w_move_legal;
    w_reject     = (r_state == S_HUMAN) && move_valid && !w_move_legal;
    w_ai_we      = (r_state == S_AI_MOVE) && w_ai_found;
    w_winner_we  = 1'b0;
    w_winner_nxt = WIN_NONE;
    if (w_clear) begin
      w_winner_we  = 1'b1;
      w_winner_nxt = WIN_NONE;
    end else if (r_state == S_EVAL_H) begin
      if (w_human_win) begin
        w_winner_we  = 1'b1;
        w_winner_nxt = WIN_HUMAN;
      end else if (w_full) begin
        w_winner_we  = 1'b1;
        w_winner_nxt = WIN_DRAW;
      end
    end else if (r_state == S_EVAL_A) begin
      if (w_ai_win) begin
        w_winner_we  = 1'b1;
        w_winner_nxt = WIN_AI;
      end else if (w_full) begin
        w_winner_we  = 1'b1;
        w_winner_nxt = WIN_DRAW;
      end
    end
  end

  // Board storage: cleared on a new game, one cell written per accepted turn.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the board is a handful of flops, not a RAM, so it takes the async reset directly.
    if (!reset_n) begin
      r_board <= '0;
    end else if (w_clear) begin
      r_board <= '0;
    end else begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        if (w_human_we && (move_pos == 4'(i + 1)))     r_board[i] <= CELL_HUMAN;
        else if (w_ai_we && (w_ai_idx == 4'(i + 1)))   r_board[i] <= CELL_AI;
      end
    end
  end

  // Winner code and the one-cycle illegal-move pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_winner  <= WIN_NONE;
      r_illegal <= 1'b0;
    end else begin
      if (w_winner_we) r_winner <= w_winner_nxt;
      r_illegal <= w_reject;
    end
  end

  assign winner  = r_winner;
  assign illegal = r_illegal;
  assign pos1    = r_board[0];
  assign pos2    = r_board[1];
  assign pos3    = r_board[2];
  assign pos4    = r_board[3];
  assign pos5    = r_board[4];
  assign pos6    = r_board[5];
  assign pos7    = r_board[6];
  assign pos8    = r_board[7];
  assign pos9    = r_board[8];

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: an independent board model predicts the
// board/winner after each human turn into a scoreboard queue, which is popped
// and compared once the controller settles back in HUMAN or DONE.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       move_valid = 1'b0;
  logic [3:0] move_pos = 4'd0;
  logic       check = 1'b0;
  logic [3:0] blockthis = 4'd0;
  logic       move_ready;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic       illegal;
  logic       game_over;
  logic [1:0] winner;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [17:0] board;
    logic [1:0]  winner;
    logic        over;
  } exp_t;

  exp_t sb_q[$];

  logic [1:0] m_board [1:9];
  logic [1:0] m_winner;
  logic       m_over;

  int lines [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                       '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

  game_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .move_valid (move_valid),
    .move_pos   (move_pos),
    .move_ready (move_ready),
    .check      (check),
    .blockthis  (blockthis),
    .pos1       (pos1),
    .pos2       (pos2),
    .pos3       (pos3),
    .pos4       (pos4),
    .pos5       (pos5),
    .pos6       (pos6),
    .pos7       (pos7),
    .pos8       (pos8),
    .pos9       (pos9),
    .illegal    (illegal),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [17:0] dut_board();
    return {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
  endfunction

  function automatic logic [17:0] model_vec();
    logic [17:0] v;
    v = '0;
    for (int i = 1; i <= 9; i++) v[2*(i-1) +: 2] = m_board[i];
    return v;
  endfunction

  function automatic bit model_wins(input logic [1:0] who);
    for (int l = 0; l < 8; l++)
      if (m_board[lines[l][0]] == who && m_board[lines[l][1]] == who && m_board[lines[l][2]] == who)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_full();
    for (int i = 1; i <= 9; i++) if (m_board[i] == 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_ai_pick(input logic chk, input int bt);
    if (chk && bt >= 1 && bt <= 9 && m_board[bt] == 2'b00) return bt;
    if (m_board[5] == 2'b00) return 5;
    for (int i = 1; i <= 9; i++) if (m_board[i] == 2'b00) return i;
    return 0;
  endfunction

  task automatic model_clear();
    for (int i = 1; i <= 9; i++) m_board[i] = 2'b00;
    m_winner = 2'b00;
    m_over   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic start_game();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
    vectors++;
    if (move_ready !== 1'b1 || dut_board() !== 18'h0 || winner !== 2'b00 || game_over !== 1'b0) begin
      miscompares++;
      $display("FAIL start_game: ready=%b board=%h winner=%b over=%b, required ready=1 board=0 winner=00 over=0",
               move_ready, dut_board(), winner, game_over);
    end
  endtask

  // Offer one legal human move, predict the full turn, then compare on settle.
  task automatic play_move(input int pos, input logic chk, input int bt);
    exp_t e;
    exp_t got;
    int   n;
    int   ai;
    n = 0;
    while (move_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    m_board[pos] = 2'b01;
    if (model_wins(2'b01)) begin
      m_winner = 2'b01; m_over = 1'b1;
    end else if (model_full()) begin
      m_winner = 2'b11; m_over = 1'b1;
    end else begin
      ai = model_ai_pick(chk, bt);
      if (ai != 0) m_board[ai] = 2'b10;
      if (model_wins(2'b10))  begin m_winner = 2'b10; m_over = 1'b1; end
      else if (model_full())  begin m_winner = 2'b11; m_over = 1'b1; end
    end
    e.board = model_vec(); e.winner = m_winner; e.over = m_over;
    sb_q.push_back(e);

    check = chk; blockthis = 4'(bt);
    move_valid = 1'b1; move_pos = 4'(pos);
    @(negedge clk);
    move_valid = 1'b0; move_pos = 4'd0;
    n = 0;
    while (move_ready !== 1'b1 && game_over !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check = 1'b0; blockthis = 4'd0;

    vectors++;
    if (n >= 20) begin
      miscompares++;
      $display("FAIL settle_timeout pos=%0d: ready=%b over=%b after %0d cycles, required ready or over",
               pos, move_ready, game_over, n);
    end
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty pos=%0d: queue size 0, required 1", pos);
    end else begin
      got = sb_q.pop_front();
      if (dut_board() !== got.board || winner !== got.winner || game_over !== got.over) begin
        miscompares++;
        $display("FAIL turn pos=%0d: board=%h winner=%b over=%b, required board=%h winner=%b over=%b",
                 pos, dut_board(), winner, game_over, got.board, got.winner, got.over);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (dut_board() !== 18'h0 || winner !== 2'b00 || illegal !== 1'b0 ||
        game_over !== 1'b0 || move_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: board=%h winner=%b illegal=%b over=%b ready=%b, required all zero",
               dut_board(), winner, illegal, game_over, move_ready);
    end
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (move_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_ready: ready=%b, required 0", move_ready);
    end
  endtask

  // Human 5, no hint: AI takes cell 1; checks exact turn latency and that
  // start/move_valid are ignored while the AI turn is in flight.
  task automatic test_first_move();
    start_game();
    move_valid = 1'b1; move_pos = 4'd5; check = 1'b0;
    m_board[5] = 2'b01;
    m_board[model_ai_pick(1'b0, 0)] = 2'b10;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      move_valid = 1'b0; move_pos = 4'd0;
      if (n == 2) begin start = 1'b1; move_valid = 1'b1; move_pos = 4'd9; end
      if (n == 3) begin
        start = 1'b0;
        vectors++;
        if (pos1 !== 2'b00 || pos5 !== 2'b01 || illegal !== 1'b0) begin
          miscompares++;
          $display("FAIL ai_write_early: pos1=%b pos5=%b illegal=%b, required 00 01 0", pos1, pos5, illegal);
        end
      end
      if (n == 4) begin
        vectors++;
        if (dut_board() !== model_vec() || move_ready !== 1'b0 || illegal !== 1'b0) begin
          miscompares++;
          $display("FAIL ai_write: board=%h ready=%b illegal=%b, required board=%h ready=0 illegal=0",
                   dut_board(), move_ready, illegal, model_vec());
        end
      end
      if (n == 5) begin
        vectors++;
        if (move_ready !== 1'b1 || dut_board() !== model_vec() || winner !== 2'b00) begin
          miscompares++;
          $display("FAIL back_to_human: ready=%b board=%h winner=%b, required ready=1 board=%h winner=00",
                   move_ready, dut_board(), winner, model_vec());
        end
      end
    end
  endtask

  // Occupied cell, then index 0, then index 12: one separate pulse each.
  task automatic test_illegal();
    int bad [3] = '{5, 0, 12};
    for (int k = 0; k < 3; k++) begin
      move_valid = 1'b1; move_pos = 4'(bad[k]);
      @(negedge clk);
      move_valid = 1'b0; move_pos = 4'd0;
      vectors++;
      if (illegal !== 1'b1 || move_ready !== 1'b1 || dut_board() !== model_vec()) begin
        miscompares++;
        $display("FAIL illegal_pulse pos=%0d: illegal=%b ready=%b board=%h, required 1 1 %h",
                 bad[k], illegal, move_ready, dut_board(), model_vec());
      end
      @(negedge clk);
      vectors++;
      if (illegal !== 1'b0 || move_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL illegal_width pos=%0d: illegal=%b ready=%b, required 0 1", bad[k], illegal, move_ready);
      end
    end
  endtask

  // Hint honoured when the suggested cell is empty, fallback when occupied.
  task automatic test_block();
    do_reset();
    start_game();
    play_move(1, 1'b0, 0);
    play_move(2, 1'b1, 3);
    vectors++;
    if (pos3 !== 2'b10) begin
      miscompares++;
      $display("FAIL block_cell3: pos3=%b, required 10", pos3);
    end
    play_move(7, 1'b1, 5);
    vectors++;
    if (pos4 !== 2'b10) begin
      miscompares++;
      $display("FAIL fallback_lowest: pos4=%b, required 10", pos4);
    end
  endtask

  // AI completes 3-5-7; DONE then ignores moves until start.
  task automatic test_ai_win();
    logic [17:0] held;
    do_reset();
    start_game();
    play_move(1, 1'b0, 0);
    play_move(2, 1'b1, 3);
    play_move(4, 1'b1, 7);
    held = dut_board();
    move_valid = 1'b1; move_pos = 4'd9;
    @(negedge clk);
    @(negedge clk);
    move_valid = 1'b0; move_pos = 4'd0;
    vectors++;
    if (dut_board() !== model_vec() || illegal !== 1'b0 || game_over !== 1'b1 || winner !== 2'b10) begin
      miscompares++;
      $display("FAIL done_ignores_move: board=%h illegal=%b over=%b winner=%b, required %h 0 1 10",
               dut_board(), illegal, game_over, winner, held);
    end
  endtask

  // New game from DONE, then a full board with no line.
  task automatic test_draw();
    start_game();
    play_move(1, 1'b0, 0);
    play_move(3, 1'b1, 2);
    play_move(4, 1'b1, 7);
    play_move(8, 1'b1, 6);
    play_move(9, 1'b0, 0);
    vectors++;
    if (winner !== 2'b11 || game_over !== 1'b1) begin
      miscompares++;
      $display("FAIL draw: winner=%b over=%b, required 11 1", winner, game_over);
    end
  endtask

  // Reset asserted in AI_WAIT aborts the turn and lands in IDLE.
  task automatic test_reset_mid_turn();
    do_reset();
    start_game();
    move_valid = 1'b1; move_pos = 4'd5;
    @(negedge clk);
    move_valid = 1'b0; move_pos = 4'd0;
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if (dut_board() !== 18'h0 || winner !== 2'b00 || move_ready !== 1'b0 ||
        game_over !== 1'b0 || illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: board=%h winner=%b ready=%b over=%b illegal=%b, required all zero",
               dut_board(), winner, move_ready, game_over, illegal);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (dut_board() !== 18'h0 || move_ready !== 1'b0 || game_over !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_write: board=%h ready=%b over=%b, required 0 0 0",
               dut_board(), move_ready, game_over);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_first_move();
    test_illegal();
    test_block();
    test_ai_win();
    test_draw();
    test_reset_mid_turn();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
